// File: rtl/trace_capture_unit_pkg.sv
// Shared definitions for the retirement trace recorder: state encoding,
// trace entry layout and the entry-packing helper.
package trace_pkg;

   typedef enum logic [1:0] {
      TRC_IDLE  = 2'd0,
      TRC_ARMED = 2'd1,
      TRC_POST  = 2'd2,
      TRC_DONE  = 2'd3
   } trc_state_t;

   localparam int RD_ADDR_W   = 5;
   localparam int MAX_XLEN    = 64;
   localparam int PACK_W      = 3*MAX_XLEN + RD_ADDR_W + 1;
   localparam int OFF_RD_ADDR = 0;
   localparam int OFF_RD_WE   = RD_ADDR_W;

   function automatic int entry_w(input int xlen);
      return 3*xlen + RD_ADDR_W + 1;
   endfunction

   function automatic int off_alu(input int xlen);
      return RD_ADDR_W + 1 + 0*xlen;
   endfunction

   function automatic int off_instr(input int xlen);
      return RD_ADDR_W + 1 + xlen;
   endfunction

   function automatic int off_pc(input int xlen);
      return RD_ADDR_W + 1 + 2*xlen;
   endfunction

   // Entry layout, MSB first: {pc, instr, alu_out, rd_we, rd_addr}.
   // Callers zero-extend the datapath fields and truncate to entry_w(xlen).
   function automatic logic [PACK_W-1:0] pack_entry(
      input int                    xlen,
      input logic [MAX_XLEN-1:0]   pc,
      input logic [MAX_XLEN-1:0]   instr,
      input logic [MAX_XLEN-1:0]   alu_out,
      input logic                  rd_we,
      input logic [RD_ADDR_W-1:0]  rd_addr
   );
      return (PACK_W'(rd_addr) << OFF_RD_ADDR)
           | (PACK_W'(rd_we)   << OFF_RD_WE)
           | (PACK_W'(alu_out) << off_alu(xlen))
           | (PACK_W'(instr)   << off_instr(xlen))
           | (PACK_W'(pc)      << off_pc(xlen));
   endfunction

endpackage

// File: rtl/trace_capture_unit_ram.sv
// Trace storage: one write port, one registered read port, no reset on the
// array so it maps onto block RAM.
module trace_ram #(
   parameter  int DW    = 102,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_capture_unit.sv
// Retirement trace recorder: circular capture with PC/external trigger and
// a post-trigger window, then frozen oldest-first readout.
module trace_capture_unit
   import trace_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  arm,
   input  logic                  trig_en,
   input  logic [XLEN-1:0]       trig_pc,
   input  logic                  ext_trig,
   input  logic [AW-1:0]         post_count,
   input  logic                  in_valid,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [XLEN-1:0]       in_instr,
   input  logic [XLEN-1:0]       in_alu_out,
   input  logic                  in_rd_we,
   input  logic [4:0]            in_rd_addr,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_idx,
   output logic [3*XLEN+5:0]     rd_data,
   output logic                  rd_valid,
   output logic [1:0]            state,
   output logic [AW:0]           entries,
   output logic [AW-1:0]         trig_idx
);

   localparam int EW = 3*XLEN + 6;

   trc_state_t    r_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_entries;
   logic [AW-1:0] r_post_left;
   logic [AW-1:0] r_post_sampled;
   logic [AW-1:0] r_trig_idx;
   logic          r_rd_valid;

   logic          w_capturing;
   logic          w_write;
   logic          w_trig;
   logic [AW:0]   w_entries_inc;
   logic [AW:0]   w_trig_calc;
   logic [AW-1:0] w_rd_phys;
   logic          w_rd_ok;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_ram_q;

   // arm wins over a same-cycle retirement: the restart cycle never writes.
   assign w_capturing   = (r_state == TRC_ARMED) || (r_state == TRC_POST);
   assign w_write       = w_capturing && in_valid && !arm;
   assign w_trig        = (r_state == TRC_ARMED) && in_valid && !arm &&
                          ((trig_en && (in_pc == trig_pc)) || ext_trig);
   assign w_entries_inc = (r_entries == (AW+1)'(DEPTH)) ? r_entries
                                                        : r_entries + 1'b1;
   assign w_trig_calc   = w_entries_inc - (AW+1)'(1) - {1'b0, r_post_sampled};

   // Entries == DEPTH truncates to 0, which is exactly the wrapped oldest slot.
   assign w_rd_phys = r_wr_ptr - r_entries[AW-1:0] + rd_idx;
   assign w_rd_ok   = rd_en && (r_state == TRC_DONE) && ({1'b0, rd_idx} < r_entries);

   assign w_entry = EW'(pack_entry(XLEN, MAX_XLEN'(in_pc), MAX_XLEN'(in_instr),
                                   MAX_XLEN'(in_alu_out), in_rd_we, in_rd_addr));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= TRC_IDLE;
         r_wr_ptr       <= '0;
         r_entries      <= '0;
         r_post_left    <= '0;
         r_post_sampled <= '0;
         r_trig_idx     <= '0;
         r_rd_valid     <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_ok;
         if (arm) begin
            r_state     <= TRC_ARMED;
            r_wr_ptr    <= '0;
            r_entries   <= '0;
            r_post_left <= '0;
         end else begin
            case (r_state)
               TRC_ARMED: begin
                  if (in_valid) begin
                     r_wr_ptr  <= r_wr_ptr + 1'b1;
                     r_entries <= w_entries_inc;
                     if (w_trig) begin
                        if (post_count == '0) begin
                           r_state    <= TRC_DONE;
                           r_trig_idx <= AW'(w_entries_inc - (AW+1)'(1));
                        end else begin
                           r_state        <= TRC_POST;
                           r_post_left    <= post_count;
                           r_post_sampled <= post_count;
                        end
                     end
                  end
               end
               TRC_POST: begin
                  if (in_valid) begin
                     r_wr_ptr    <= r_wr_ptr + 1'b1;
                     r_entries   <= w_entries_inc;
                     r_post_left <= r_post_left - 1'b1;
                     if (r_post_left == AW'(1)) begin
                        r_state    <= TRC_DONE;
                        r_trig_idx <= w_trig_calc[AW-1:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   trace_ram #(
      .DW    (EW),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_write),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_entry),
      .i_re    (w_rd_ok),
      .i_raddr (w_rd_phys),
      .o_rdata (w_ram_q)
   );

   // The RAM output register has no reset, so gate it with the reset-clean valid.
   assign rd_data  = r_rd_valid ? w_ram_q : '0;
   assign rd_valid = r_rd_valid;
   assign state    = r_state;
   assign entries  = r_entries;
   assign trig_idx = r_trig_idx;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for the trace recorder: no-wrap, wrap, external trigger,
// read boundaries, re-arm priority and asynchronous reset.
module tb_trace_capture_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int EW    = 3*XLEN + 6;

   logic            clk;
   logic            reset_n;
   logic            arm;
   logic            trig_en;
   logic [XLEN-1:0] trig_pc;
   logic            ext_trig;
   logic [AW-1:0]   post_count;
   logic            in_valid;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_alu_out;
   logic            in_rd_we;
   logic [4:0]      in_rd_addr;
   logic            rd_en;
   logic [AW-1:0]   rd_idx;
   logic [EW-1:0]   rd_data;
   logic            rd_valid;
   logic [1:0]      state;
   logic [AW:0]     entries;
   logic [AW-1:0]   trig_idx;

   int n_vec  = 0;
   int n_fail = 0;

   trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (arm),
      .trig_en    (trig_en),
      .trig_pc    (trig_pc),
      .ext_trig   (ext_trig),
      .post_count (post_count),
      .in_valid   (in_valid),
      .in_pc      (in_pc),
      .in_instr   (in_instr),
      .in_alu_out (in_alu_out),
      .in_rd_we   (in_rd_we),
      .in_rd_addr (in_rd_addr),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .state      (state),
      .entries    (entries),
      .trig_idx   (trig_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] exp_entry(input logic [31:0] pc);
      return {pc, pc ^ 32'hA5A5_0000, pc + 32'd1000, pc[2], pc[6:2]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic ext);
      in_valid   = 1'b1;
      in_pc      = pc;
      in_instr   = pc ^ 32'hA5A5_0000;
      in_alu_out = pc + 32'd1000;
      in_rd_we   = pc[2];
      in_rd_addr = pc[6:2];
      ext_trig   = ext;
      tick();
      in_valid   = 1'b0;
      ext_trig   = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [AW-1:0] idx,
                           input logic exp_v, input logic [EW-1:0] exp_d);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en  = 1'b0;
      check({tag, "_valid"}, 128'(rd_valid), 128'(exp_v));
      check({tag, "_data"},  128'(rd_data),  128'(exp_d));
      tick();
      check({tag, "_drop"},  128'(rd_valid), 128'(0));
   endtask

   initial begin
      reset_n = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; ext_trig = 1'b0;
      post_count = '0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_alu_out = '0;
      in_rd_we = 1'b0; in_rd_addr = '0; rd_en = 1'b0; rd_idx = '0;
      repeat (3) tick();
      check("rst_state",    128'(state),    128'(0));
      check("rst_entries",  128'(entries),  128'(0));
      check("rst_trig_idx", 128'(trig_idx), 128'(0));
      check("rst_rd_valid", 128'(rd_valid), 128'(0));
      check("rst_rd_data",  128'(rd_data),  128'(0));
      reset_n = 1'b1;
      tick();

      // IDLE ignores retirements
      retire(32'h40, 1'b1);
      check("idle_state",   128'(state),   128'(0));
      check("idle_entries", 128'(entries), 128'(0));

      // No-wrap capture
      trig_en = 1'b1; trig_pc = 32'h20; post_count = 4'd2;
      do_arm();
      check("t1_armed", 128'(state), 128'(1));
      for (int i = 0; i < 12; i++) begin
         retire(32'(4*i), 1'b0);
         if (i == 8) check("t1_post", 128'(state), 128'(2));
      end
      check("t1_state",    128'(state),    128'(3));
      check("t1_entries",  128'(entries),  128'(11));
      check("t1_trig_idx", 128'(trig_idx), 128'(8));
      read_chk("t1_rd0",  4'd0,  1'b1, exp_entry(32'h00));
      read_chk("t1_rd10", 4'd10, 1'b1, exp_entry(32'h28));

      // Wrap: last 16 of 40 entries are PCs 0x60..0x9C
      trig_pc = 32'h90; post_count = 4'd3;
      do_arm();
      check("t2_rearm_entries", 128'(entries), 128'(0));
      for (int i = 0; i < 40; i++) retire(32'(4*i), 1'b0);
      check("t2_state",    128'(state),    128'(3));
      check("t2_entries",  128'(entries),  128'(16));
      check("t2_trig_idx", 128'(trig_idx), 128'(12));
      read_chk("t2_rd0",  4'd0,  1'b1, exp_entry(32'h60));
      read_chk("t2_rd12", 4'd12, 1'b1, exp_entry(32'h90));
      read_chk("t2_rd15", 4'd15, 1'b1, exp_entry(32'h9C));

      // Immediate stop on external trigger, plus early read
      trig_en = 1'b0; post_count = 4'd0;
      do_arm();
      read_chk("t3_early", 4'd0, 1'b0, '0);
      for (int i = 0; i < 4; i++) retire(32'h400 + 32'(4*i), 1'b0);
      ext_trig = 1'b1;
      tick();
      ext_trig = 1'b0;
      check("t3_ext_no_valid", 128'(state), 128'(1));
      retire(32'h410, 1'b1);
      check("t3_state",    128'(state),    128'(3));
      check("t3_entries",  128'(entries),  128'(5));
      check("t3_trig_idx", 128'(trig_idx), 128'(4));
      read_chk("t3_rd4", 4'd4, 1'b1, exp_entry(32'h410));
      read_chk("t3_rd7", 4'd7, 1'b0, '0);

      // Re-arm priority over a same-cycle matching retirement
      trig_en = 1'b1; trig_pc = 32'h100; post_count = 4'd5;
      do_arm();
      retire(32'hF8, 1'b0);
      retire(32'hFC, 1'b0);
      retire(32'h100, 1'b0);
      check("t4_post", 128'(state), 128'(2));
      retire(32'h104, 1'b0);
      in_valid = 1'b1; in_pc = 32'h100; arm = 1'b1;
      tick();
      in_valid = 1'b0; arm = 1'b0;
      check("t4_rearm_state",   128'(state),   128'(1));
      check("t4_rearm_entries", 128'(entries), 128'(0));
      trig_pc = 32'h204; post_count = 4'd1;
      retire(32'h200, 1'b0);
      retire(32'h204, 1'b0);
      retire(32'h208, 1'b0);
      check("t4_state",    128'(state),    128'(3));
      check("t4_entries",  128'(entries),  128'(3));
      check("t4_trig_idx", 128'(trig_idx), 128'(1));
      read_chk("t4_rd0", 4'd0, 1'b1, exp_entry(32'h200));
      read_chk("t4_rd2", 4'd2, 1'b1, exp_entry(32'h208));

      // Asynchronous reset mid-POST, between clock edges
      trig_pc = 32'h300; post_count = 4'd4;
      do_arm();
      retire(32'h300, 1'b0);
      retire(32'h304, 1'b0);
      check("t5_pre_post", 128'(state), 128'(2));
      #2;
      reset_n = 1'b0;
      #1;
      check("t5_async_state",    128'(state),    128'(0));
      check("t5_async_entries",  128'(entries),  128'(0));
      check("t5_async_rd_valid", 128'(rd_valid), 128'(0));
      tick();
      reset_n = 1'b1;
      retire(32'h308, 1'b0);
      retire(32'h300, 1'b1);
      check("t5_idle_state",   128'(state),   128'(0));
      check("t5_idle_entries", 128'(entries), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
